regfile_wb_arbiter: RTL

- Shares the register file's single write port (WE3/A3/WD3) among NUM_REQ write-back sources, e.g. ALU, load unit and multiplier.
- Arbitrates with round-robin priority and registers the winning write for one cycle before it reaches the register file.
- Maintains a per-register pending-write busy mask so issue logic can stall on RAW hazards.
- Suppresses writes to register 0.

---
 rtl/regfile_wb_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for a single-write-port register file.
// The winning write is registered for one cycle, and a pending-write busy mask is kept for hazard stalls.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      busy_set_en,
  input  logic [ADDR_W-1:0]         busy_set_addr,
  output logic                      we3,
  output logic [ADDR_W-1:0]         a3,
  output logic [DATA_W-1:0]         wd3,
  output logic [2**ADDR_W-1:0]      busy_mask
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  next_ptr;
  logic              found;
  logic              transfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Arbitration looks only at req_valid and rr_ptr, so ready never loops back through a requester.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    cand      = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && rst_n) req_ready[grant_idx] = 1'b1;
  end

  assign transfer = found & rst_n;
  assign sel_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];
  assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      we3    <= 1'b0;
      a3     <= '0;
      wd3    <= '0;
    end else begin
      we3 <= 1'b0;
      if (transfer) begin
        rr_ptr <= next_ptr;
        a3     <= sel_addr;
        wd3    <= sel_data;
        we3    <= (sel_addr != '0);
      end
    end
  end

  // The set comes after the clear, so a newly issued producer wins over the commit of the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask <= '0;
    end else begin
      if (we3) busy_mask[a3] <= 1'b0;
      if (busy_set_en && (busy_set_addr != '0)) busy_mask[busy_set_addr] <= 1'b1;
    end
  end

endmodule
